// File: rtl/oser8_tx.sv
// 8:1 serializer, LSB first, FRAME marks bit 0; word appears on DOUT the edge it is accepted.
// Backpressure: DREADY is high for one load slot per frame; unclaimed slots carry TRAIN_PAT/IDLE_PAT.
module oser8_tx #(
  parameter logic [7:0] TRAIN_PAT = 8'hF0,
  parameter logic [7:0] IDLE_PAT  = 8'h00
) (
  input  logic       ECLK,
  input  logic       RSTN,
  input  logic [7:0] DIN,
  input  logic       DVALID,
  output logic       DREADY,
  input  logic       TRAIN,
  input  logic       SLIPWD,
  output logic       DOUT,
  output logic       FRAME
);

  logic [2:0] cnt;
  logic [7:0] sr;
  logic       run;
  logic       slip_d;
  logic       pend;

  logic [2:0] cnt_inc;
  logic       hold;
  logic       slip_edge;
  logic [7:0] word;

  assign DREADY = run & (cnt == 3'd7) & ~pend;

  always_comb begin
    hold      = run & (cnt == 3'd7) & pend;
    slip_edge = SLIPWD & ~slip_d;
    cnt_inc   = cnt + 3'd1;
    word      = DVALID ? DIN : (TRAIN ? TRAIN_PAT : IDLE_PAT);
  end

  always_ff @(posedge ECLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt    <= 3'd7;
      sr     <= 8'h00;
      run    <= 1'b0;
      slip_d <= 1'b0;
      pend   <= 1'b0;
      DOUT   <= 1'b0;
      FRAME  <= 1'b0;
    end else begin
      slip_d <= SLIPWD;
      // A hold consumes the pending slip; any edge arriving with it is dropped.
      if (hold)
        pend <= 1'b0;
      else if (slip_edge)
        pend <= 1'b1;

      if (!run) begin
        run <= 1'b1;
      end else if (DREADY) begin
        sr    <= word;
        DOUT  <= word[0];
        FRAME <= 1'b1;
        cnt   <= 3'd0;
      end else if (hold) begin
        // bit 7 stays on DOUT one extra period
        FRAME <= 1'b0;
      end else begin
        cnt   <= cnt_inc;
        DOUT  <= sr[cnt_inc];
        FRAME <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oser8_tx.sv
// Bench for oser8_tx: edge-numbered reference model feeds a queue; a negedge monitor compares.
module tb_oser8_tx;

  localparam logic [7:0] TP = 8'hF0;
  localparam logic [7:0] IP = 8'h00;

  logic       ECLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DVALID = 1'b0;
  logic       DREADY;
  logic       TRAIN = 1'b0;
  logic       SLIPWD = 1'b0;
  logic       DOUT;
  logic       FRAME;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  oser8_tx #(.TRAIN_PAT(TP), .IDLE_PAT(IP)) dut (
    .ECLK(ECLK), .RSTN(RSTN), .DIN(DIN), .DVALID(DVALID), .DREADY(DREADY),
    .TRAIN(TRAIN), .SLIPWD(SLIPWD), .DOUT(DOUT), .FRAME(FRAME)
  );

  always #5 ECLK = ~ECLK;
  always @(posedge ECLK) cyc++;

  // Reference model: edges are numbered from reset release; frames are scheduled
  // by the edge at which they end (next load or a one-edge hold).
  logic [2:0] expq[$];
  int         n, next_end, e_start;
  logic [7:0] m_word;
  logic       m_pend, m_slip_prev, m_dout, m_frame, m_rdy, m_is_hold, m_edge;

  always @(posedge ECLK) begin
    if (!RSTN) begin
      n = 0; next_end = 2; e_start = 0; m_word = 8'h00;
      m_pend = 1'b0; m_slip_prev = 1'b0; m_dout = 1'b0; m_frame = 1'b0;
      expq.push_back(3'b000);
    end else begin
      m_edge = SLIPWD & ~m_slip_prev;
      m_slip_prev = SLIPWD;
      m_is_hold = 1'b0;
      n++;
      if (n == 1) begin
        m_frame = 1'b0;
      end else if (n == next_end) begin
        if (m_pend) begin
          m_pend = 1'b0; m_is_hold = 1'b1; next_end = n + 1; m_frame = 1'b0;
        end else begin
          m_word = DVALID ? DIN : (TRAIN ? TP : IP);
          e_start = n; next_end = n + 8;
          m_dout = m_word[0]; m_frame = 1'b1;
        end
      end else begin
        if (n - e_start >= 0 && n - e_start <= 7) m_dout = m_word[n - e_start];
        m_frame = 1'b0;
      end
      if (m_edge && !m_pend && !m_is_hold) m_pend = 1'b1;
      m_rdy = (next_end == n + 1) && !m_pend;
      expq.push_back({m_rdy, m_frame, m_dout});
    end
  end

  // Monitor: reset overrides the queued expectation since it acts immediately.
  always @(negedge ECLK) begin
    logic [2:0] e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      if (!RSTN) e = 3'b000;
      total += 3;
      if (DOUT !== e[0]) begin bad++; $display("FAIL dout cyc=%0d got=%b exp=%b", cyc, DOUT, e[0]); end
      if (FRAME !== e[1]) begin bad++; $display("FAIL frame cyc=%0d got=%b exp=%b", cyc, FRAME, e[1]); end
      if (DREADY !== e[2]) begin bad++; $display("FAIL dready cyc=%0d got=%b exp=%b", cyc, DREADY, e[2]); end
    end
  end

  task automatic send(input logic [7:0] w);
    DIN = w;
    DVALID = 1'b1;
    for (int k = 0; k < 40 && !DREADY; k++) @(negedge ECLK);
    total++;
    if (!DREADY) begin
      bad++;
      $display("FAIL send_timeout word=%h dready stayed %b", w, DREADY);
    end else begin
      @(negedge ECLK);
    end
    DVALID = 1'b0;
  endtask

  task automatic wait_frame(output int c);
    for (int k = 0; k < 20; k++) begin
      @(negedge ECLK);
      if (FRAME) break;
    end
    total++;
    if (FRAME !== 1'b1) begin
      bad++;
      $display("FAIL frame_timeout frame=%b exp=1", FRAME);
    end
    c = cyc;
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  initial begin
    int c0, f0, f1, f2, f3;
    repeat (3) @(negedge ECLK);
    RSTN = 1'b1;
    c0 = cyc;
    send(8'hA5);
    check_int("first_accept_edge", cyc - c0, 2);
    send(8'h3C);
    repeat (24) @(negedge ECLK);

    // training pattern, then a data word arriving mid-frame
    TRAIN = 1'b1;
    repeat (20) @(negedge ECLK);
    wait_frame(f0);
    repeat (3) @(negedge ECLK);
    send(8'h81);
    repeat (12) @(negedge ECLK);

    // single slip plus a second edge while pending
    wait_frame(f1);
    @(negedge ECLK); SLIPWD = 1'b1;
    @(negedge ECLK); SLIPWD = 1'b0;
    @(negedge ECLK); SLIPWD = 1'b1;
    @(negedge ECLK); SLIPWD = 1'b0;
    wait_frame(f2);
    check_int("slip_frame_gap", f2 - f1, 9);
    wait_frame(f3);
    check_int("post_slip_gap", f3 - f2, 8);

    // held slip request: only one hold
    wait_frame(f0);
    SLIPWD = 1'b1;
    fork
      begin repeat (30) @(negedge ECLK); SLIPWD = 1'b0; end
    join_none
    for (int i = 0; i < 5; i++) wait_frame(f1);
    check_int("held_slip_span", f1 - f0, 41);
    repeat (4) @(negedge ECLK);

    // reset during bit 4 of 8'hFF
    TRAIN = 1'b0;
    send(8'hFF);
    repeat (4) @(negedge ECLK);
    #2 RSTN = 1'b0;
    #1;
    check_int("rst_dout", int'(DOUT), 0);
    check_int("rst_frame", int'(FRAME), 0);
    check_int("rst_dready", int'(DREADY), 0);
    @(negedge ECLK);
    @(negedge ECLK);
    RSTN = 1'b1;
    c0 = cyc;
    send(8'h5A);
    check_int("reaccept_edge", cyc - c0, 2);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 5))
        0, 1: send(8'($urandom));
        2: begin
          TRAIN = 1'($urandom);
          repeat ($urandom_range(1, 12)) @(negedge ECLK);
        end
        3: begin
          SLIPWD = 1'b1;
          repeat ($urandom_range(1, 4)) @(negedge ECLK);
          SLIPWD = 1'b0;
          @(negedge ECLK);
        end
        4: begin
          if (!DREADY) begin
            DIN = 8'($urandom);
            DVALID = 1'b1;
            @(negedge ECLK);
            DVALID = 1'b0;
          end
          @(negedge ECLK);
        end
        default: begin
          send(8'($urandom));
          send(8'($urandom));
        end
      endcase
    end
    repeat (20) @(negedge ECLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
